// File: rtl/second_tick_gen.sv
// Prescaled tick, seconds counter and second-aligned pulse generator.
// Define SECOND_TICK_SYNC_IN_EN to add the SYNC alignment input and the ARM state.
module second_tick_gen #(
    parameter int unsigned CLK_HZ       = 10000000,
    parameter int unsigned TICK_HZ      = 1000,
    parameter int unsigned PULSE_CYCLES = 100000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ENABLE,
`ifdef SECOND_TICK_SYNC_IN_EN
    input  logic        SYNC,
`endif
    output logic        TICK,
    output logic        SEC_PULSE,
    output logic [31:0] SECONDS,
    output logic        RUNNING
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned TW  = (TICK_HZ > 1) ? $clog2(TICK_HZ) : 1;
    localparam int unsigned WW  = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

    localparam logic [PW-1:0] PRE_LAST   = PW'(DIV - 1);
    localparam logic [TW-1:0] TICKS_LAST = TW'(TICK_HZ - 1);
    localparam logic [WW-1:0] WIDTH_LAST = WW'(PULSE_CYCLES - 1);

    if (CLK_HZ % TICK_HZ != 0) begin : g_bad_div
        $error("CLK_HZ must be an integer multiple of TICK_HZ");
    end
    if (PULSE_CYCLES < 1 || PULSE_CYCLES >= CLK_HZ) begin : g_bad_pulse
        $error("PULSE_CYCLES must lie in 1..CLK_HZ-1");
    end

    typedef enum logic [1:0] {StIdle, StArm, StRun} state_e;

    // Reset asserts asynchronously but releases two edges after RESET rises.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    logic w_sync_edge;

`ifdef SECOND_TICK_SYNC_IN_EN
    logic r_sync_meta;
    logic r_sync_sync;
    logic r_sync_prev;

    always_ff @(posedge CLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_sync_meta <= 1'b0;
            r_sync_sync <= 1'b0;
            r_sync_prev <= 1'b0;
        end else begin
            r_sync_meta <= SYNC;
            r_sync_sync <= r_sync_meta;
            r_sync_prev <= r_sync_sync;
        end
    end

    assign w_sync_edge = r_sync_sync & ~r_sync_prev;
`else
    assign w_sync_edge = 1'b0;
`endif

    state_e        r_state;
    logic [PW-1:0] r_prescaler;
    logic [TW-1:0] r_ticks;
    logic [WW-1:0] r_width;
    logic [31:0]   r_seconds;
    logic          r_tick;
    logic          r_sec_strobe;
    logic          r_sec_pulse;

    logic w_pre_last;
    logic w_boundary;

    assign w_pre_last = (r_prescaler == PRE_LAST);
    assign w_boundary = w_pre_last && (r_ticks == TICKS_LAST);

    always_ff @(posedge CLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state      <= StIdle;
            r_prescaler  <= '0;
            r_ticks      <= '0;
            r_width      <= '0;
            r_seconds    <= '0;
            r_tick       <= 1'b0;
            r_sec_strobe <= 1'b0;
            r_sec_pulse  <= 1'b0;
        end else if (!ENABLE) begin
            r_state      <= StIdle;
            r_prescaler  <= '0;
            r_ticks      <= '0;
            r_width      <= '0;
            r_tick       <= 1'b0;
            r_sec_strobe <= 1'b0;
            r_sec_pulse  <= 1'b0;
        end else begin
            r_tick       <= 1'b0;
            r_sec_strobe <= 1'b0;

            // A new boundary restarts the width count even mid-pulse.
            if (r_sec_strobe) begin
                r_sec_pulse <= 1'b1;
                r_width     <= '0;
            end else if (r_sec_pulse) begin
                if (r_width == WIDTH_LAST) begin
                    r_sec_pulse <= 1'b0;
                    r_width     <= '0;
                end else begin
                    r_width <= r_width + 1'b1;
                end
            end

            case (r_state)
                StIdle: begin
                    r_prescaler <= '0;
                    r_ticks     <= '0;
`ifdef SECOND_TICK_SYNC_IN_EN
                    r_state     <= StArm;
`else
                    r_state     <= StRun;
`endif
                end
                StArm: begin
                    if (w_sync_edge) begin
                        r_state <= StRun;
                    end
                end
                StRun: begin
                    // A natural boundary wins over a coincident SYNC edge.
                    if (w_boundary) begin
                        r_tick       <= 1'b1;
                        r_sec_strobe <= 1'b1;
                        r_seconds    <= r_seconds + 32'd1;
                        r_prescaler  <= '0;
                        r_ticks      <= '0;
                    end else if (w_sync_edge) begin
                        r_prescaler <= '0;
                        r_ticks     <= '0;
                    end else if (w_pre_last) begin
                        r_tick      <= 1'b1;
                        r_prescaler <= '0;
                        r_ticks     <= r_ticks + 1'b1;
                    end else begin
                        r_prescaler <= r_prescaler + 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign TICK      = r_tick;
    assign SEC_PULSE = r_sec_pulse;
    assign SECONDS   = r_seconds;
    assign RUNNING   = (r_state == StRun);

endmodule

// File: doc/second_tick_gen.md
SECOND_TICK_GEN -- requirements
Module: second_tick_gen

Interface
REQ-001 SHALL have parameter CLK_HZ, default 10000000, input clock frequency in Hz (PLL 10 MHz global output).
REQ-002 SHALL have parameter TICK_HZ, default 1000, TICK strobe rate in Hz; CLK_HZ % TICK_HZ != 0 SHALL be an elaboration error.
REQ-003 SHALL have parameter PULSE_CYCLES, default 100000, SEC_PULSE width in CLK cycles, 1..CLK_HZ-1.
REQ-004 SHALL have port CLK input 1, the single clock, driven from the PLL global output.
REQ-005 SHALL have port RESET input 1, asynchronous active-low reset.
REQ-006 SHALL have port ENABLE input 1, synchronous run request.
REQ-007 SHALL have port SYNC input 1, asynchronous external alignment pulse; present only with SYNC_IN_EN.
REQ-008 SHALL have port TICK output 1, one-cycle strobe every CLK_HZ/TICK_HZ cycles.
REQ-009 SHALL have port SEC_PULSE output 1, high for PULSE_CYCLES cycles from each second boundary.
REQ-010 SHALL have port SECONDS output 32, count of completed seconds.
REQ-011 SHALL have port RUNNING output 1, high in state RUN.

Function
REQ-012 SHALL implement states IDLE, ARM, RUN; IDLE->RUN on ENABLE=1 without SYNC_IN_EN, IDLE->ARM with it; ARM->RUN on a detected SYNC edge; any state->IDLE on ENABLE=0.
REQ-013 SHALL count prescaler 0..DIV-1 (DIV=CLK_HZ/TICK_HZ) only in RUN, starting at 0 on RUN entry; TICK=1 (registered) in the cycle prescaler equals DIV-1.
REQ-014 SHALL count ticks 0..TICK_HZ-1, advancing on each TICK; the TICK where ticks equals TICK_HZ-1 is a second boundary.
REQ-015 SHALL at a second boundary set ticks to 0, increment SECONDS by 1 modulo 2^32 (0xFFFFFFFF->0), and assert SEC_PULSE in the following cycle.
REQ-016 SHALL hold SEC_PULSE high for exactly PULSE_CYCLES cycles via width counter; a boundary during an active pulse SHALL restart the width count.
REQ-017 SHALL on entry to IDLE clear prescaler, ticks, width counter, TICK, SEC_PULSE the next cycle; SECONDS SHALL be retained.
REQ-018 SHALL give first TICK exactly DIV cycles after the RUN-entry cycle and first SEC_PULSE rise CLK_HZ+1 cycles after it.
REQ-019 SHALL size counters as ceil(log2) of their ranges; no counter SHALL exceed its terminal value.

Reset
REQ-020 SHALL with RESET=0 asynchronously force state IDLE, all counters 0, SECONDS=0, TICK=0, SEC_PULSE=0, RUNNING=0.
REQ-021 SHALL release reset synchronously to CLK (internal two-flop deassertion synchronizer); first state change no earlier than 2nd CLK edge after RESET rises.
REQ-022 SHALL abort any operation on reset mid-pulse or mid-count with no residual outputs.

Configuration
REQ-023 SHALL compile SYNC support in only when macro SECOND_TICK_SYNC_IN_EN is defined.
REQ-024 SHALL with SECOND_TICK_SYNC_IN_EN: synchronize SYNC via two flops, detect rising edge (edge seen 3 cycles after pin rise), use it for ARM->RUN, and in RUN zero prescaler and ticks on the edge without emitting TICK, SECONDS increment or SEC_PULSE for the partial period.
REQ-025 SHALL with SECOND_TICK_SYNC_IN_EN: a SYNC edge coinciding with a natural second boundary emits the boundary (TICK, SECONDS+1, SEC_PULSE), counters resume from 0.
REQ-026 SHALL without SECOND_TICK_SYNC_IN_EN: omit SYNC port and synchronizer, ARM unreachable.

Verification (CLK_HZ=100, TICK_HZ=10, PULSE_CYCLES=5 unless noted)
REQ-027 SHALL verify reset then ENABLE=1 (no macro) -> TICK every 10 cycles, first at cycle 10; SECONDS=1 and SEC_PULSE high 5 cycles starting cycle 101.
REQ-028 SHALL verify SECONDS preloaded near wrap by running 0xFFFFFFFF boundary (force) -> next boundary yields SECONDS=0.
REQ-029 SHALL verify ENABLE dropped mid-SEC_PULSE at cycle 102 -> SEC_PULSE, TICK low next cycle, SECONDS stays 1; re-enable restarts prescaler at 0.
REQ-030 SHALL verify macro on: ENABLE=1, SYNC pulse at cycle 20 -> ARM until edge, RUN at cycle 23, first TICK at cycle 33.
REQ-031 SHALL verify macro on: SYNC in RUN at prescaler 6 -> no TICK, next TICK 10 cycles after edge; SYNC on boundary -> SECONDS increments once.
REQ-032 SHALL verify RESET asserted at cycle 55 mid-run -> all outputs 0 immediately, SECONDS=0, state IDLE.
